// File: rtl/l1_dcache_pkg.sv
// Shared types, widths and address helpers for the two-way L1 data cache.
package dcache_types;

    localparam int unsigned S_INDEX  = 3;
    localparam int unsigned S_OFFSET = 5;
    localparam int unsigned NUM_WAYS = 2;
    localparam int unsigned TAG_W    = 24;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned OFF_W    = 5;
    localparam int unsigned LINE_W   = 256;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NUM_SETS = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL
    } state_e;

    // Byte address of the first byte of a line.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, OFF_W'(0)};
    endfunction

    // 32-bit word at word offset 'off' within a line.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [2:0]        off);
        return line[{off, 5'd0} +: WORD_W];
    endfunction

endpackage

// File: rtl/l1_dcache_way.sv
// One cache way: tag/valid/dirty/data flip-flop arrays, async read, clocked writes.
module dcache_way
    import dcache_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              word_we_i,
    input  logic [2:0]        off_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        be_i,
    input  logic              line_we_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] line_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0]   data_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [WORD_W-1:0]   new_word;

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    // Byte-masked merge of store data into the addressed word.
    always_comb begin
        new_word = line_word(data_q[idx_i], off_i);
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                new_word[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    // Data and tag storage; a line fill takes priority over a word store.
    always_ff @(posedge clk) begin
        if (line_we_i) begin
            data_q[idx_i] <= line_i;
            tag_q[idx_i]  <= tag_i;
        end else if (word_we_i) begin
            data_q[idx_i][{off_i, 5'd0} +: WORD_W] <= new_word;
        end
    end

    // Valid/dirty state: fills bring lines in clean, stores mark them dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// Two-way set-associative write-back, write-allocate L1 data cache.
module l1_dcache
    import dcache_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [2:0]          req_off;
    logic                req_valid;
    logic                addr_unused;

    state_e              state_q, state_d;
    logic [NUM_SETS-1:0] lru_q, lru_d;
    logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]    miss_idx_q, miss_idx_d;
    logic                victim_q, victim_d;

    logic [IDX_W-1:0]    idx_sel;
    logic [NUM_WAYS-1:0] way_valid, way_dirty, way_hit, word_we, line_we;
    logic [TAG_W-1:0]    way_tag  [NUM_WAYS];
    logic [LINE_W-1:0]   way_line [NUM_WAYS];
    logic                hit, hit_way, victim_way;

    assign req_tag     = mem_address[31:8];
    assign req_idx     = mem_address[7:5];
    assign req_off     = mem_address[4:2];
    assign req_valid   = mem_read | mem_write;
    assign addr_unused = ^mem_address[1:0];

    // While a miss is outstanding the arrays follow the latched miss index.
    assign idx_sel = (state_q == WRITEBACK || state_q == FILL) ? miss_idx_q : req_idx;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        dcache_way u_way (
            .clk       (clk),
            .rst       (rst),
            .idx_i     (idx_sel),
            .word_we_i (word_we[w]),
            .off_i     (req_off),
            .wdata_i   (mem_wdata),
            .be_i      (mem_byte_enable),
            .line_we_i (line_we[w]),
            .tag_i     (miss_tag_q),
            .line_i    (pmem_rdata),
            .valid_o   (way_valid[w]),
            .dirty_o   (way_dirty[w]),
            .tag_o     (way_tag[w]),
            .line_o    (way_line[w])
        );
        assign way_hit[w] = way_valid[w] && (way_tag[w] == req_tag);
    end

    assign hit     = |way_hit;
    assign hit_way = way_hit[1];

    // Victim: first invalid way (way0 first), else the LRU way of the set.
    always_comb begin
        if (!way_valid[0]) begin
            victim_way = 1'b0;
        end else if (!way_valid[1]) begin
            victim_way = 1'b1;
        end else begin
            victim_way = lru_q[req_idx];
        end
    end

    // Next-state, array write enables and memory-side strobes.
    always_comb begin
        state_d      = state_q;
        lru_d        = lru_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        victim_d     = victim_q;
        word_we      = '0;
        line_we      = '0;
        mem_resp     = 1'b0;
        mem_rdata    = line_word(way_line[hit_way], req_off);
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = way_line[victim_q];

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!req_valid) begin
                    state_d = IDLE;
                end else if (hit) begin
                    mem_resp         = 1'b1;
                    word_we[hit_way] = mem_write;
                    lru_d[req_idx]   = ~hit_way;
                    state_d          = IDLE;
                end else begin
                    miss_tag_d = req_tag;
                    miss_idx_d = req_idx;
                    victim_d   = victim_way;
                    if (way_valid[victim_way] && way_dirty[victim_way]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = line_addr(way_tag[victim_q], miss_idx_q);
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = line_addr(miss_tag_q, miss_idx_q);
                if (pmem_resp) begin
                    line_we[victim_q] = 1'b1;
                    state_d           = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, LRU and latched miss context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lru_q   <= '0;
        end else begin
            state_q    <= state_d;
            lru_q      <= lru_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            victim_q   <= victim_d;
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache with a memory-side responder and a reference model.
module tb_l1_dcache;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address, mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    l1_dcache dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory (line granularity) and CPU-visible word view.
    logic [255:0] mem_lines [logic [31:0]];
    logic [31:0]  ref_mem   [logic [31:0]];

    function automatic logic [255:0] backing_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w*4)) ^ 32'hA5A5_0000;
        return l;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0]  wa;
        logic [255:0] l;
        wa = {a[31:2], 2'b00};
        if (ref_mem.exists(wa)) return ref_mem[wa];
        l = backing_line({a[31:5], 5'b0});
        return l[int'(a[4:2])*32 +: 32];
    endfunction

    // Per-set recency list: entry 0 is most recently used.
    logic [23:0] m_tag   [8][2];
    bit          m_dirty [8][2];
    int          m_cnt   [8];

    task automatic model_reset();
        for (int s = 0; s < 8; s++) m_cnt[s] = 0;
        ref_mem.delete();
    endtask

    // Memory-side responder: pmem_resp in the mem_delay-th cycle of a strobe.
    int mem_delay = 3;
    bit hold_resp = 0;
    int rd_count  = 0;
    int wb_count  = 0;

    initial begin : responder
        int wcount;
        wcount     = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pmem_resp = 1'b0;
                wcount    = 0;
            end else begin
                if (pmem_resp) begin
                    pmem_resp = 1'b0;
                    wcount    = 0;
                end
                if (pmem_read || pmem_write) begin
                    wcount++;
                    if (wcount >= mem_delay && !hold_resp) begin
                        pmem_resp = 1'b1;
                        if (pmem_write) begin
                            mem_lines[pmem_address] = pmem_wdata;
                            wb_count++;
                        end else begin
                            pmem_rdata = backing_line(pmem_address);
                            rd_count++;
                        end
                    end
                end else begin
                    wcount = 0;
                end
            end
        end
    end

    // Expectations published by the driver.
    bit           active      = 0;
    int           resp_cyc    = -1;
    bit           chk_rdata   = 0;
    logic [31:0]  exp_rdata   = '0;
    bit           exp_fill_v  = 0;
    bit           exp_wb_v    = 0;
    logic [31:0]  exp_fill_addr = '0;
    logic [31:0]  exp_wb_addr   = '0;
    logic [255:0] exp_wb_line   = '0;
    logic [31:0]  last_rd_addr  = '0;
    logic [31:0]  last_wr_addr  = '0;
    logic [255:0] last_wr_data  = '0;
    logic [31:0]  last_rdata    = '0;
    int           resp_count    = 0;

    // Per-cycle comparison of DUT outputs against the model's expectations.
    always @(negedge clk) begin
        if (!rst) begin
            check("mem_resp", mem_resp, active && (cyc == resp_cyc));
            if (mem_resp) begin
                resp_count++;
                last_rdata = mem_rdata;
                if (active && chk_rdata) check("mem_rdata", mem_rdata, exp_rdata);
            end
            check("pmem_exclusive", pmem_read & pmem_write, 1'b0);
            if (pmem_read)  last_rd_addr = pmem_address;
            if (pmem_write) begin
                last_wr_addr = pmem_address;
                last_wr_data = pmem_wdata;
            end
            if (!exp_fill_v) check("pmem_read_unexpected", pmem_read, 1'b0);
            else if (pmem_read) check("pmem_read_addr", pmem_address, exp_fill_addr);
            if (!exp_wb_v) check("pmem_write_unexpected", pmem_write, 1'b0);
            else if (pmem_write) begin
                check("pmem_write_addr", pmem_address, exp_wb_addr);
                check("pmem_wdata", pmem_wdata, exp_wb_line);
            end
        end
    end

    // One CPU request: update the model, publish expectations, drive and wait.
    task automatic do_req(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [31:0] wd, input logic [3:0] be);
        logic [23:0] tag;
        int          idx, lat, hw, n;
        bit          d;
        logic [31:0] pre, merged;
        tag = a[31:8];
        idx = int'(a[7:5]);
        hw  = -1;
        pre = ref_word(a);
        exp_fill_v = 0;
        exp_wb_v   = 0;
        for (int i = 0; i < m_cnt[idx]; i++) if (m_tag[idx][i] == tag) hw = i;
        if (hw >= 0) begin
            lat = 2;
            d   = m_dirty[idx][hw];
            if (hw == 1) begin
                m_tag[idx][1]   = m_tag[idx][0];
                m_dirty[idx][1] = m_dirty[idx][0];
            end
            m_tag[idx][0]   = tag;
            m_dirty[idx][0] = d;
        end else begin
            lat           = 2 + mem_delay + 1;
            exp_fill_v    = 1;
            exp_fill_addr = {tag, 3'(idx), 5'b0};
            if (m_cnt[idx] == 2) begin
                if (m_dirty[idx][1]) begin
                    lat         = lat + mem_delay;
                    exp_wb_v    = 1;
                    exp_wb_addr = {m_tag[idx][1], 3'(idx), 5'b0};
                    for (int w = 0; w < 8; w++)
                        exp_wb_line[w*32 +: 32] = ref_word(exp_wb_addr + 32'(w*4));
                end
            end else begin
                m_cnt[idx]++;
            end
            m_tag[idx][1]   = m_tag[idx][0];
            m_dirty[idx][1] = m_dirty[idx][0];
            m_tag[idx][0]   = tag;
            m_dirty[idx][0] = 1'b0;
        end
        if (wr) begin
            m_dirty[idx][0] = 1'b1;
            merged = pre;
            for (int b = 0; b < 4; b++) if (be[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[{a[31:2], 2'b00}] = merged;
        end
        @(posedge clk);
        #1;
        mem_address     = a;
        mem_read        = rd;
        mem_write       = wr;
        mem_wdata       = wd;
        mem_byte_enable = be;
        exp_rdata       = pre;
        chk_rdata       = rd;
        resp_cyc        = cyc + lat - 1;
        active          = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_resp && n < 200);
        if (!mem_resp) check("resp_timeout", mem_resp, 1'b1);
        @(posedge clk);
        #1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        active     = 0;
        exp_fill_v = 0;
        exp_wb_v   = 0;
    endtask

    task automatic wait_pmem_read(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pmem_read && n < 50);
        check(name, pmem_read, 1'b1);
    endtask

    // Read miss that is abandoned while the fill is in flight (set must not be full).
    task automatic do_drop_in_fill(input logic [31:0] a);
        int idx, rc, n;
        idx           = int'(a[7:5]);
        exp_fill_v    = 1;
        exp_fill_addr = {a[31:5], 5'b0};
        @(posedge clk);
        #1;
        mem_address = a;
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        active      = 1;
        resp_cyc    = -1;
        wait_pmem_read("drop_fill_started");
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        rc = rd_count;
        n  = 0;
        while (rd_count == rc && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drop_fill_completed", rd_count, rc + 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        active     = 0;
        exp_fill_v = 0;
        m_tag[idx][m_cnt[idx]]   = a[31:8];
        m_dirty[idx][m_cnt[idx]] = 1'b0;
        m_cnt[idx]++;
    endtask

    // Read miss interrupted by reset while the fill response is withheld.
    task automatic do_reset_in_fill(input logic [31:0] a);
        hold_resp     = 1;
        exp_fill_v    = 1;
        exp_fill_addr = {a[31:5], 5'b0};
        @(posedge clk);
        #1;
        mem_address = a;
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        active      = 1;
        resp_cyc    = -1;
        wait_pmem_read("rst_fill_started");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        active   = 0;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_fill_v = 0;
        hold_resp  = 0;
        @(negedge clk);
        check("rst_pmem_read_dropped", pmem_read, 1'b0);
        check("rst_mem_resp_low", mem_resp, 1'b0);
        model_reset();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [255:0] l;
        int rc, wb;
        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        l = backing_line(32'h0000_1000);
        l[63:32] = 32'hDEAD_BEEF;
        mem_lines[32'h0000_1000] = l;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_mem_resp", mem_resp, 1'b0);
        check("reset_pmem_read", pmem_read, 1'b0);
        check("reset_pmem_write", pmem_write, 1'b0);

        // Cold read miss then re-read hit.
        do_req(32'h0000_1004, 1, 0, '0, '0);
        check("cold_rdata", last_rdata, 32'hDEAD_BEEF);
        check("cold_fill_addr", last_rd_addr, 32'h0000_1000);
        check("cold_resp_count", resp_count, 1);
        rc = rd_count;
        do_req(32'h0000_1004, 1, 0, '0, '0);
        check("reread_no_fill", rd_count, rc);

        // Write hit, then read back the merged word.
        do_req(32'h0000_1004, 0, 1, 32'h0000_00AA, 4'b0001);
        do_req(32'h0000_1004, 1, 0, '0, '0);
        check("write_hit_rdata", last_rdata, 32'hDEAD_BEAA);
        check("write_hit_no_wb", wb_count, 0);

        // Third tag in set 0 evicts the dirty LRU line.
        do_req(32'h0000_2000, 1, 0, '0, '0);
        do_req(32'h0000_3000, 1, 0, '0, '0);
        check("evict_wb_addr", last_wr_addr, 32'h0000_1000);
        check("evict_wb_word1", last_wr_data[63:32], 32'hDEAD_BEAA);
        check("evict_fill_addr", last_rd_addr, 32'h0000_3000);
        check("evict_wb_count", wb_count, 1);

        // Alternating hits decide the victim; a clean victim is not written back.
        do_req(32'h0000_2000, 1, 0, '0, '0);
        do_req(32'h0000_3000, 1, 0, '0, '0);
        do_req(32'h0000_2000, 1, 0, '0, '0);
        wb = wb_count;
        do_req(32'h0000_1000, 1, 0, '0, '0);
        check("clean_victim_no_wb", wb_count, wb);
        check("clean_victim_fill", last_rd_addr, 32'h0000_1000);
        do_req(32'h0000_1004, 1, 0, '0, '0);
        check("refetched_dirty_data", last_rdata, 32'hDEAD_BEAA);

        // Read+write together acts as a write, returning the pre-merge word.
        do_req(32'h0000_1008, 1, 1, 32'h1234_0000, 4'b1100);
        check("rw_pre_merge", last_rdata, 32'hA5A5_1008);
        do_req(32'h0000_1008, 1, 0, '0, '0);
        check("rw_merged", last_rdata, 32'h1234_1008);

        // Write-allocate miss in another set, with a one-cycle memory.
        mem_delay = 1;
        do_req(32'h0000_5024, 0, 1, 32'hCAFE_F00D, 4'b1111);
        do_req(32'h0000_5024, 1, 0, '0, '0);
        check("write_alloc_rdata", last_rdata, 32'hCAFE_F00D);
        mem_delay = 3;

        // Reset during a fill drops the strobes and invalidates the cache.
        do_reset_in_fill(32'h0000_7040);
        rc = rd_count;
        do_req(32'h0000_7040, 1, 0, '0, '0);
        check("post_rst_refill", rd_count, rc + 1);
        do_req(32'h0000_1004, 1, 0, '0, '0);
        check("post_rst_rdata", last_rdata, 32'hDEAD_BEAA);

        // Abandoned fill keeps the line; the re-request hits without memory traffic.
        do_drop_in_fill(32'h0000_9060);
        rc = rd_count;
        do_req(32'h0000_9060, 1, 0, '0, '0);
        check("drop_rereq_no_fill", rd_count, rc);
        check("drop_rereq_rdata", last_rdata, 32'hA5A5_9060);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
